// File: rtl/sis_avmm_rw_arbiter.sv
// ---------------------------------------------------------------------------
// sis_avmm_rw_arbiter
//
// Two-requester Avalon-MM arbiter. Two avmm_0_rw masters (m0, m1) share one
// read/write slave port (s_*) leading to the VGA register/memory bridge.
//
//   * Round-robin arbitration; a grant that the slave stalls is held until
//     the slave accepts it, so the granted master's request stays stable.
//   * The request path is a pure combinational mux (no added wait states).
//   * Read data returns through a fixed-latency tag pipeline that steers
//     readdatavalid back to the requester that issued the read. Both readdata
//     outputs are wired straight to s_readdata.
//
// Optional feature macro: SIS_ARB_LOCK_EN
//   When defined, m0_lock / m1_lock exist. A transfer accepted with lock=1
//   keeps the grant on that requester until it is accepted with lock=0 or
//   it stops requesting (atomic CRTC index/data pairs).
//
// Parameters:
//   ADDR_W        address width
//   DATA_W        data width (byteenable is DATA_W/8)
//   READ_LATENCY  fixed slave read latency in cycles, legal range 1..8
//
// Ports:
//   clock, resetn                 clock, asynchronous active-low reset
//   m{0,1}_address/byteenable/read/write/writedata   requester request
//   m{0,1}_waitrequest            requester stall
//   m{0,1}_readdata/readdatavalid requester read return
//   m{0,1}_lock                   (SIS_ARB_LOCK_EN only) keep grant
//   s_address/byteenable/read/write/writedata        slave request
//   s_readdata, s_waitrequest     slave response and stall
// ---------------------------------------------------------------------------
module sis_avmm_rw_arbiter #(
    parameter int ADDR_W       = 64,
    parameter int DATA_W       = 64,
    parameter int READ_LATENCY = 1
) (
    input  logic                clock,
    input  logic                resetn,

    input  logic [ADDR_W-1:0]   m0_address,
    input  logic [DATA_W/8-1:0] m0_byteenable,
    input  logic                m0_read,
    input  logic                m0_write,
    input  logic [DATA_W-1:0]   m0_writedata,
    output logic                m0_waitrequest,
    output logic [DATA_W-1:0]   m0_readdata,
    output logic                m0_readdatavalid,

    input  logic [ADDR_W-1:0]   m1_address,
    input  logic [DATA_W/8-1:0] m1_byteenable,
    input  logic                m1_read,
    input  logic                m1_write,
    input  logic [DATA_W-1:0]   m1_writedata,
    output logic                m1_waitrequest,
    output logic [DATA_W-1:0]   m1_readdata,
    output logic                m1_readdatavalid,

`ifdef SIS_ARB_LOCK_EN
    input  logic                m0_lock,
    input  logic                m1_lock,
`endif

    output logic [ADDR_W-1:0]   s_address,
    output logic [DATA_W/8-1:0] s_byteenable,
    output logic                s_read,
    output logic                s_write,
    output logic [DATA_W-1:0]   s_writedata,
    input  logic [DATA_W-1:0]   s_readdata,
    input  logic                s_waitrequest
);

    // Requests and arbitration state
    logic req0;
    logic req1;
    logic last;         // last requester accepted; 1 after reset so m0 wins first
    logic held;         // a stalled grant is pending
    logic owner;        // requester holding the stalled grant
    logic grant_valid;
    logic grant_id;
    logic s_req;
    logic accept;
    logic stall;

`ifdef SIS_ARB_LOCK_EN
    logic lock_act;     // grant is locked to lock_id
    logic lock_id;
    logic grant_lock;
    logic lock_req;
`endif

    // Tag pipeline: tag_v[0] is the newest entry, tag_v[READ_LATENCY-1] the
    // one whose data the slave is presenting this cycle.
    logic [READ_LATENCY-1:0] tag_v;
    logic [READ_LATENCY-1:0] tag_id;

    assign req0 = m0_read | m0_write;
    assign req1 = m1_read | m1_write;

`ifdef SIS_ARB_LOCK_EN
    assign lock_req   = lock_id ? req1 : req0;
    assign grant_lock = grant_id ? m1_lock : m0_lock;
`endif

    // Grant selection. A held grant always goes to its owner, even if the
    // owner illegally dropped its strobe: the slave strobes then read 0 and
    // nothing is accepted, which also releases the hold.
    // NOTE: every output of this always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        grant_valid = 1'b0;
        grant_id    = 1'b0;
        if (held) begin
            grant_valid = 1'b1;
            grant_id    = owner;
        end
`ifdef SIS_ARB_LOCK_EN
        else if (lock_act && lock_req) begin
            grant_valid = 1'b1;
            grant_id    = lock_id;
        end
`endif
        else if (req0 && req1) begin
            grant_valid = 1'b1;
            grant_id    = ~last;
        end else if (req0) begin
            grant_valid = 1'b1;
            grant_id    = 1'b0;
        end else if (req1) begin
            grant_valid = 1'b1;
            grant_id    = 1'b1;
        end
    end

    // Zero-latency request mux. Address/data follow the selected requester
    // unconditionally; only the strobes are qualified by the grant.
    assign s_address    = grant_id ? m1_address    : m0_address;
    assign s_byteenable = grant_id ? m1_byteenable : m0_byteenable;
    assign s_writedata  = grant_id ? m1_writedata  : m0_writedata;
    assign s_read       = grant_valid & (grant_id ? m1_read  : m0_read);
    assign s_write      = grant_valid & (grant_id ? m1_write : m0_write);

    assign s_req  = s_read | s_write;
    assign accept = s_req & ~s_waitrequest;
    assign stall  = s_req &  s_waitrequest;

    // A requesting master sees the slave stall when granted and a forced
    // stall otherwise; an idle master sees no stall.
    assign m0_waitrequest = req0 & ((grant_valid & ~grant_id) ? s_waitrequest : 1'b1);
    assign m1_waitrequest = req1 & ((grant_valid &  grant_id) ? s_waitrequest : 1'b1);

    // Round-robin pointer and stall hold.
    // NOTE: sequential state is written with non-blocking assignments so all
    // registers update from the same pre-edge values.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            last  <= 1'b1;
            held  <= 1'b0;
            owner <= 1'b0;
        end else begin
            // held is simply "the slave stalled the granted strobe this
            // cycle"; acceptance and a dropped strobe both clear it.
            held <= stall;
            if (stall) begin
                owner <= grant_id;
            end
            if (accept) begin
                last <= grant_id;
            end
        end
    end

`ifdef SIS_ARB_LOCK_EN
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            lock_act <= 1'b0;
            lock_id  <= 1'b0;
        end else if (accept) begin
            lock_act <= grant_lock;
            lock_id  <= grant_id;
        end else if (lock_act && !lock_req) begin
            lock_act <= 1'b0;
        end
    end
`endif

    // Read-return tag pipeline.
    // NOTE: the whole pipeline is reset, not just its valid bits, so a reset
    // in the middle of a read return drops every in-flight tag at once.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            tag_v  <= '0;
            tag_id <= '0;
        end else begin
            for (int i = READ_LATENCY - 1; i > 0; i--) begin
                tag_v[i]  <= tag_v[i-1];
                tag_id[i] <= tag_id[i-1];
            end
            tag_v[0]  <= accept & s_read;
            tag_id[0] <= grant_id;
        end
    end

    assign m0_readdatavalid = tag_v[READ_LATENCY-1] & ~tag_id[READ_LATENCY-1];
    assign m1_readdatavalid = tag_v[READ_LATENCY-1] &  tag_id[READ_LATENCY-1];
    assign m0_readdata      = s_readdata;
    assign m1_readdata      = s_readdata;

endmodule

// File: doc/sis_avmm_rw_arbiter.md
# sis_avmm_rw_arbiter

Two-requester Avalon-MM arbiter sharing one 64-bit read/write slave port between SiS fbdev HLS components, for example two `SiS_Generic_ConvertCRData` instances or one such instance plus a register-init sequencer.
- Round-robin arbitration with grant held across slave stalls.
- Read data is steered back to its originator through a fixed-latency tag pipeline.
- Sits between the components' `avmm_0_rw` masters and the shared VGA register/memory bridge.

## Interface
Parameters:
- `ADDR_W`, 64: address width.
- `DATA_W`, 64: data width; byteenable width is `DATA_W/8`.
- `READ_LATENCY`, 1: fixed slave read latency in cycles, from read acceptance to readdata; legal range 1–8.

Ports:
- `clock` in 1: single clock.
- `resetn` in 1: asynchronous, active-low reset.
- `m0_address` / `m1_address` in ADDR_W: requester address.
- `m0_byteenable` / `m1_byteenable` in DATA_W/8: requester byte lanes.
- `m0_read` / `m1_read`, `m0_write` / `m1_write` in 1: request strobes; read and write are never both high on one requester.
- `m0_writedata` / `m1_writedata` in DATA_W: write data.
- `m0_waitrequest` / `m1_waitrequest` out 1: requester stall.
- `m0_readdata` / `m1_readdata` out DATA_W: returned read data.
- `m0_readdatavalid` / `m1_readdatavalid` out 1: read data valid, one per accepted read.
- `m0_lock` / `m1_lock` in 1: present only with `SIS_ARB_LOCK_EN`.
- `s_address` out ADDR_W, `s_byteenable` out DATA_W/8, `s_read` out 1, `s_write` out 1, `s_writedata` out DATA_W: slave-side request.
- `s_readdata` in DATA_W, `s_waitrequest` in 1: slave-side response and stall.

## Operation
- Request: `req_i = mi_read | mi_write`.
- State: `last` (1 bit, last requester granted), `held` (1 bit), `owner` (1 bit), `tag_v`/`tag_id` shift registers of depth READ_LATENCY.
- Grant, combinational:
  - `held=1`: grant `owner`.
  - Otherwise, only one requester active: it wins.
  - Otherwise, both active: the requester != `last` wins.
  - Neither active: no grant; all slave strobes are 0.
- The granted requester's address, byteenable, read, write and writedata are muxed to `s_*`. Non-granted requesters see `waitrequest=1` while requesting.
- Granted requester: `mi_waitrequest = s_waitrequest`. Idle requesters see `waitrequest=0`.
- Acceptance is `(s_read|s_write) & !s_waitrequest`.
  - On acceptance: `last <= grant`, `held <= 0`.
  - On a stalled grant: `held <= 1`, `owner <= grant`. No re-arbitration occurs until acceptance, so request signals stay stable per Avalon rules.
- Read return:
  - An accepted read pushes `tag_v=1` and `tag_id=grant` into the pipeline. Every other cycle pushes `tag_v=0`.
  - At pipeline output, `m{tag_id}_readdatavalid=1` and `m{tag_id}_readdata=s_readdata`. Both readdata outputs are driven from `s_readdata` continuously; only the valid flags are steered.
- A requester dropping its strobe while held is a protocol violation. The arbiter clears `held` that cycle: slave strobes follow the dropped request (0) and nothing is accepted.

## Timing
- Request path to slave is zero latency (combinational mux); there are no added wait states.
- Back-to-back accepted transfers are allowed every cycle. With both requesters continuously active, grants alternate m0, m1, m0, …
- Read data appears on `m{i}_readdatavalid` exactly READ_LATENCY cycles after the acceptance edge.
- Reads from different requesters may be pipelined; returns arrive in acceptance order.
- Reset values:
  - `last=1`, so m0 wins the first contention.
  - `held=0`, `owner=0`, all tags 0.
  - All `readdatavalid` outputs 0.
  - `s_read`, `s_write` and both `waitrequest` outputs follow their combinational equations from the reset state; they are 0 when no requester is active.
- Reset asserted mid-transfer or mid-read-return clears all tags immediately. In-flight read data is dropped and no `readdatavalid` is produced.
- Same-cycle `m0` and `m1` requests with `held=1`: the owner is served and the other requester waits.

## Configuration
- `SIS_ARB_LOCK_EN` defined:
  - `mi_lock` ports exist.
  - If requester i has an accepted transfer while `mi_lock=1`, the grant stays with i for the following cycles, ignoring round-robin, until a cycle in which i is accepted with `mi_lock=0` or i stops requesting.
  - Used for atomic CRTC index/data pairs.
- Undefined: lock ports are absent and arbitration is pure round-robin as above.

## Test plan
- **Single requester:** reset, m0 write addr 0x3D4 data 0x11 byteenable 0x01, `s_waitrequest=0` -> `s_write=1`, `s_address=0x3D4` the same cycle; `m0_waitrequest=0`.
- **Contention after reset:** m0 and m1 both write continuously for 4 cycles -> accepted order m0, m1, m0, m1.
- **Slave stall:** m1 read granted while `s_waitrequest=1` for 3 cycles, m0 requests in cycle 2 -> grant stays m1 until acceptance, then m0 is granted next cycle.
- **Read steering, READ_LATENCY=2:**
  - Stimulus: m0 read, then m1 read back-to-back; `s_readdata` = 0xAA then 0xBB.
  - Required: `m0_readdatavalid` 2 cycles after first acceptance with 0xAA, `m1_readdatavalid` next cycle with 0xBB.
- **Reset mid-read:** `resetn` low 1 cycle after an accepted read -> no `readdatavalid` ever produced for it; `last` returns to 1.
- **Lock (`SIS_ARB_LOCK_EN`):** m0 issues 2 writes with `m0_lock=1` on the first, m1 requesting throughout -> both m0 writes accepted consecutively before m1.
